// File: rtl/la_cmd_slave.sv
// la_cmd_slave: device-side UART command endpoint of the logic analyzer.
// Two received 8N1 bytes (high byte first) form one 16-bit command for the
// command processor; 8-bit responses are serialised back to the host.
// The RX and TX paths share no state and run full duplex.
module la_cmd_slave #(
  parameter int BAUD_DIV = 868,
  parameter int TIMEOUT  = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        tx_busy,
  output logic        resp_sent,
  output logic        frm_err
);

  localparam int CW = 16;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] BAUD_FULL = CW'(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] CNT_ONE   = 16'd1;
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE    = TW'(1);
  localparam logic [TW-1:0] TO_ZERO   = TW'(0);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic {AS_WAIT_HI = 1'b0, AS_WAIT_LO = 1'b1} as_state_t;
  typedef enum logic {TX_IDLE = 1'b0, TX_SHIFT = 1'b1} tx_state_t;

  // RX path signals
  logic            rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_t       rx_state_r, rx_next_s;
  logic [CW-1:0]   rx_cnt_r;
  logic [2:0]      rx_bits_r;
  logic [7:0]      rx_shift_r;
  logic            byte_vld_r, byte_vld_d;
  logic            frm_err_r, frm_err_d;
  logic            rx_fall_s, rx_tick_s;

  // Command assembly signals
  as_state_t       as_state_r, as_next_s;
  logic [7:0]      hi_byte_r;
  logic [TW-1:0]   to_cnt_r;
  logic            to_expire_s;
  logic [15:0]     cmd_r, cmd_d;
  logic            cmd_rdy_r, cmd_rdy_d;

  // TX path signals
  tx_state_t       tx_state_r, tx_next_s;
  logic [9:0]      tx_shift_r;
  logic [CW-1:0]   tx_cnt_r;
  logic [3:0]      tx_bit_r;
  logic            tx_busy_r, tx_busy_d;
  logic            resp_sent_r, resp_sent_d;
  logic            tx_tick_s, tx_last_s;

  assign rx_fall_s   = rx_prev_r & ~rx_sync_r;
  assign rx_tick_s   = (rx_cnt_r == CNT_ONE);
  assign to_expire_s = (as_state_r == AS_WAIT_LO) && (rx_state_r == RX_IDLE) && (to_cnt_r == TO_LAST);
  assign tx_tick_s   = (tx_cnt_r == CNT_ONE);
  assign tx_last_s   = tx_tick_s && (tx_bit_r == 4'd9);

  assign TX        = tx_shift_r[0];
  assign cmd       = cmd_r;
  assign cmd_rdy   = cmd_rdy_r;
  assign tx_busy   = tx_busy_r;
  assign resp_sent = resp_sent_r;
  assign frm_err   = frm_err_r;

  // Two-flop RX synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= RX;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // RX state register, bit-time counter and data shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= BAUD_HALF;
      rx_bits_r  <= 3'd0;
      rx_shift_r <= 8'h00;
      byte_vld_r <= 1'b0;
      frm_err_r  <= 1'b0;
    end else begin
      rx_state_r <= rx_next_s;
      byte_vld_r <= byte_vld_d;
      frm_err_r  <= frm_err_d;
      if (rx_state_r == RX_IDLE) begin
        // Half a bit first so later samples land mid-bit
        rx_cnt_r  <= BAUD_HALF;
        rx_bits_r <= 3'd0;
      end else if (rx_tick_s) begin
        rx_cnt_r <= BAUD_FULL;
        if (rx_state_r == RX_DATA) begin
          rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
          rx_bits_r  <= rx_bits_r + 3'd1;
        end
      end else begin
        rx_cnt_r <= rx_cnt_r - CNT_ONE;
      end
    end
  end

  // RX next-state: start detect, glitch reject, 8 data samples, stop sample
  always_comb begin
    rx_next_s = rx_state_r;
    case (rx_state_r)
      RX_IDLE:  if (rx_fall_s) rx_next_s = RX_START; else rx_next_s = RX_IDLE;
      RX_START: if (rx_tick_s) rx_next_s = rx_sync_r ? RX_IDLE : RX_DATA; else rx_next_s = RX_START;
      RX_DATA:  if (rx_tick_s && (rx_bits_r == 3'd7)) rx_next_s = RX_STOP; else rx_next_s = RX_DATA;
      RX_STOP:  if (rx_tick_s) rx_next_s = RX_IDLE; else rx_next_s = RX_STOP;
      default:  rx_next_s = RX_IDLE;
    endcase
  end

  // RX outputs: byte-valid or framing-error strobe at the stop-bit sample
  always_comb begin
    byte_vld_d = 1'b0;
    frm_err_d  = 1'b0;
    if ((rx_state_r == RX_STOP) && rx_tick_s) begin
      byte_vld_d = rx_sync_r;
      frm_err_d  = ~rx_sync_r;
    end else begin
      byte_vld_d = 1'b0;
      frm_err_d  = 1'b0;
    end
  end

  // Assembly state, held high byte, inter-byte timeout and command registers
  always_ff @(posedge clk) begin
    if (rst) begin
      as_state_r <= AS_WAIT_HI;
      hi_byte_r  <= 8'h00;
      to_cnt_r   <= TO_ZERO;
      cmd_r      <= 16'h0000;
      cmd_rdy_r  <= 1'b0;
    end else begin
      as_state_r <= as_next_s;
      cmd_r      <= cmd_d;
      cmd_rdy_r  <= cmd_rdy_d;
      if (as_state_r == AS_WAIT_HI) begin
        to_cnt_r <= TO_ZERO;
        if (byte_vld_r) hi_byte_r <= rx_shift_r;
      end else if (rx_state_r == RX_IDLE) begin
        // Only line-idle time counts; a frame in progress holds the count
        to_cnt_r <= to_cnt_r + TO_ONE;
      end
    end
  end

  // Assembly next-state: low byte, framing error or timeout all end WAIT_LO
  always_comb begin
    as_next_s = as_state_r;
    case (as_state_r)
      AS_WAIT_HI: if (byte_vld_r) as_next_s = AS_WAIT_LO; else as_next_s = AS_WAIT_HI;
      AS_WAIT_LO: if (byte_vld_r || frm_err_r || to_expire_s) as_next_s = AS_WAIT_HI;
                  else as_next_s = AS_WAIT_LO;
      default:    as_next_s = AS_WAIT_HI;
    endcase
  end

  // Assembly outputs: whole-command update; a completing command beats a clear
  always_comb begin
    cmd_d     = cmd_r;
    cmd_rdy_d = cmd_rdy_r;
    if ((as_state_r == AS_WAIT_LO) && byte_vld_r) begin
      cmd_d     = {hi_byte_r, rx_shift_r};
      cmd_rdy_d = 1'b1;
    end else if (clr_cmd_rdy || ((as_state_r == AS_WAIT_HI) && byte_vld_r)) begin
      cmd_rdy_d = 1'b0;
    end else begin
      cmd_rdy_d = cmd_rdy_r;
    end
  end

  // TX state register, frame shift register (bit 0 drives TX) and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_r  <= TX_IDLE;
      tx_shift_r  <= 10'h3FF;
      tx_cnt_r    <= BAUD_FULL;
      tx_bit_r    <= 4'd0;
      tx_busy_r   <= 1'b0;
      resp_sent_r <= 1'b0;
    end else begin
      tx_state_r  <= tx_next_s;
      tx_busy_r   <= tx_busy_d;
      resp_sent_r <= resp_sent_d;
      if (tx_state_r == TX_IDLE) begin
        if (send_resp) tx_shift_r <= {1'b1, resp, 1'b0};
        else           tx_shift_r <= 10'h3FF;
        tx_cnt_r <= BAUD_FULL;
        tx_bit_r <= 4'd0;
      end else if (tx_tick_s) begin
        // Ones shift in behind the frame, so the line is high once it ends
        tx_shift_r <= {1'b1, tx_shift_r[9:1]};
        tx_cnt_r   <= BAUD_FULL;
        tx_bit_r   <= tx_bit_r + 4'd1;
      end else begin
        tx_cnt_r <= tx_cnt_r - CNT_ONE;
      end
    end
  end

  // TX next-state: start on request when idle, return after the stop bit
  always_comb begin
    tx_next_s = tx_state_r;
    case (tx_state_r)
      TX_IDLE:  if (send_resp) tx_next_s = TX_SHIFT; else tx_next_s = TX_IDLE;
      TX_SHIFT: if (tx_last_s) tx_next_s = TX_IDLE; else tx_next_s = TX_SHIFT;
      default:  tx_next_s = TX_IDLE;
    endcase
  end

  // TX outputs: busy for the whole frame, done pulse as the stop bit ends
  always_comb begin
    tx_busy_d   = 1'b0;
    resp_sent_d = 1'b0;
    case (tx_state_r)
      TX_IDLE:  if (send_resp) tx_busy_d = 1'b1; else tx_busy_d = 1'b0;
      TX_SHIFT: if (tx_last_s) begin
                  tx_busy_d   = 1'b0;
                  resp_sent_d = 1'b1;
                end else begin
                  tx_busy_d = 1'b1;
                end
      default:  tx_busy_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_la_cmd_slave.sv
// tb_la_cmd_slave: directed scenarios plus randomized full-duplex traffic for
// la_cmd_slave, checked against a command/response model kept in the bench.
`timescale 1ns/1ps
module tb_la_cmd_slave;

  localparam int B  = 8;
  localparam int TO = 400;
  // Sync flops (2) + edge detect (1) + half bit + 8 data + stop + byte-valid (1)
  localparam int RX_LAT = 4 + B / 2 + 9 * B;

  logic        clk = 1'b0;
  logic        rst, RX, TX;
  logic [15:0] cmd;
  logic        cmd_rdy, clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp, tx_busy, resp_sent, frm_err;

  always #5 clk = ~clk;

  la_cmd_slave #(.BAUD_DIV(B), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
    .tx_busy(tx_busy), .resp_sent(resp_sent), .frm_err(frm_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0, frm_cnt = 0, rise_cnt = 0, rise_cyc = 0;
  int c0, r0, seen;
  logic rdy_q = 1'b0;

  // Reference model state
  logic [15:0] exp_cmd;
  logic        exp_rdy;
  int          exp_frm;

  // Free-running cycle count
  always @(posedge clk) cyc <= cyc + 1;

  // Count frm_err pulses and cmd_rdy rising edges
  always @(negedge clk) begin
    if (frm_err) frm_cnt <= frm_cnt + 1;
    if (cmd_rdy && !rdy_q) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    rdy_q <= cmd_rdy;
  end

  // Guard against a hung run
  initial begin
    #5_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one 8N1 frame on RX, LSB first; stop_ok=0 forces a bad stop bit
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    RX = 1'b0;
    ticks(B);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      ticks(B);
    end
    RX = stop_ok;
    ticks(B);
    RX = 1'b1;
  endtask

  task automatic check_model();
    check_val("cmd", cmd, exp_cmd);
    check_val("cmd_rdy", cmd_rdy, exp_rdy);
    check_val("frm_err_count", frm_cnt, exp_frm);
  endtask

  // Request a response and check the whole serial frame bit by bit
  task automatic tx_frame(input logic [7:0] b, input bit poke40);
    logic [9:0] frame;
    logic [7:0] win;
    int early, not_busy;
    frame = {1'b1, b, 1'b0};
    early = 0;
    not_busy = 0;
    resp = b;
    send_resp = 1'b1;
    ticks(1);
    send_resp = 1'b0;
    for (int i = 0; i < 10; i++) begin
      win = 8'h00;
      for (int j = 0; j < B; j++) begin
        win[j] = TX;
        if (resp_sent) early++;
        if (!tx_busy) not_busy++;
        send_resp = poke40 && (i * B + j == 40);
        if (send_resp) resp = ~b;
        ticks(1);
      end
      check_val($sformatf("tx_bit%0d_of_%02h", i, b), win, frame[i] ? 8'hFF : 8'h00);
    end
    send_resp = 1'b0;
    check_val("tx_sent_early", early, 0);
    check_val("tx_busy_in_frame", not_busy, 0);
    check_val("resp_sent", resp_sent, 1);
    check_val("tx_busy_end", tx_busy, 0);
    check_val("tx_idle_high", TX, 1);
  endtask

  // Random command traffic with model update per operation
  task automatic rx_random_ops(input int n);
    logic [7:0] hi, lo;
    int op;
    for (int k = 0; k < n; k++) begin
      op = $urandom_range(0, 4);
      hi = 8'($urandom);
      lo = 8'($urandom);
      case (op)
        0: begin
          send_byte(hi, 1'b1);
          check_val("rdy_cleared_by_hi", cmd_rdy, 0);
          ticks($urandom_range(0, 40));
          send_byte(lo, 1'b1);
          exp_cmd = {hi, lo};
          exp_rdy = 1'b1;
        end
        1: begin
          send_byte(lo, 1'b1);
          exp_rdy = 1'b0;
          ticks($urandom_range(420, 470));
          send_byte(hi, 1'b1);
          send_byte(lo, 1'b1);
          exp_cmd = {hi, lo};
          exp_rdy = 1'b1;
        end
        2: begin
          send_byte(hi, 1'b1);
          send_byte(lo, 1'b0);
          exp_rdy = 1'b0;
          exp_frm++;
        end
        3: begin
          clr_cmd_rdy = 1'b1;
          ticks(1);
          clr_cmd_rdy = 1'b0;
          exp_rdy = 1'b0;
        end
        default: begin
          send_byte(hi, 1'b0);
          exp_frm++;
        end
      endcase
      ticks(3);
      check_model();
    end
  endtask

  initial begin
    rst = 1'b1;
    RX = 1'b1;
    send_resp = 1'b0;
    clr_cmd_rdy = 1'b0;
    resp = 8'h00;
    exp_cmd = 16'h0000;
    exp_rdy = 1'b0;
    exp_frm = 0;
    ticks(4);
    check_val("rst_TX", TX, 1);
    check_val("rst_cmd", cmd, 0);
    check_val("rst_cmd_rdy", cmd_rdy, 0);
    check_val("rst_tx_busy", tx_busy, 0);
    check_val("rst_resp_sent", resp_sent, 0);
    check_val("rst_frm_err", frm_err, 0);
    rst = 1'b0;
    ticks(4);

    // Basic command with exact cmd_rdy latency
    send_byte(8'h86, 1'b1);
    c0 = cyc;
    send_byte(8'h16, 1'b1);
    ticks(3);
    exp_cmd = 16'h8616;
    exp_rdy = 1'b1;
    check_model();
    check_val("rdy_latency", rise_cyc - c0, RX_LAT);
    check_val("rdy_rises", rise_cnt, 1);

    // Timeout drops a lone high byte
    r0 = rise_cnt;
    send_byte(8'h05, 1'b1);
    ticks(500);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    ticks(3);
    exp_cmd = 16'h1234;
    exp_rdy = 1'b1;
    check_model();
    check_val("rdy_rise_once", rise_cnt - r0, 1);

    // Framing error on the low byte drops the partial command
    send_byte(8'h77, 1'b1);
    send_byte(8'h99, 1'b0);
    ticks(3);
    exp_rdy = 1'b0;
    exp_frm = 1;
    check_model();
    send_byte(8'hC0, 1'b1);
    send_byte(8'h00, 1'b1);
    ticks(3);
    exp_cmd = 16'hC000;
    exp_rdy = 1'b1;
    check_model();

    // Short low glitch is not a start bit
    RX = 1'b0;
    ticks(3);
    RX = 1'b1;
    ticks(100);
    check_model();

    // Clear coinciding with command completion: set wins
    send_byte(8'hAB, 1'b1);
    fork
      send_byte(8'hCD, 1'b1);
      begin
        ticks(RX_LAT - 1);
        clr_cmd_rdy = 1'b1;
        ticks(1);
        clr_cmd_rdy = 1'b0;
      end
    join
    ticks(3);
    exp_cmd = 16'hABCD;
    exp_rdy = 1'b1;
    check_model();
    clr_cmd_rdy = 1'b1;
    ticks(1);
    clr_cmd_rdy = 1'b0;
    ticks(2);
    exp_rdy = 1'b0;
    check_model();

    // Response frame with an ignored mid-frame request, then a chained frame
    tx_frame(8'hA5, 1'b1);
    tx_frame(8'h3C, 1'b0);
    ticks(5);

    // Reset in the middle of a transmitted frame
    resp = 8'h77;
    send_resp = 1'b1;
    ticks(1);
    send_resp = 1'b0;
    ticks(35);
    check_val("tx_bit4_low", TX, 0);
    rst = 1'b1;
    ticks(1);
    rst = 1'b0;
    check_val("rst_mid_TX", TX, 1);
    check_val("rst_mid_busy", tx_busy, 0);
    exp_cmd = 16'h0000;
    exp_rdy = 1'b0;
    check_val("rst_mid_cmd", cmd, exp_cmd);
    check_val("rst_mid_rdy", cmd_rdy, exp_rdy);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (resp_sent) seen++;
      ticks(1);
    end
    check_val("no_sent_after_rst", seen, 0);
    tx_frame(8'h00, 1'b0);
    ticks(4);

    // Randomized full-duplex traffic
    fork
      rx_random_ops(14);
      begin
        for (int k = 0; k < 6; k++) begin
          ticks($urandom_range(0, 30));
          tx_frame(8'($urandom), 1'b0);
        end
      end
    join
    ticks(5);
    check_model();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
